tweak_schedule_seq: RTL and testbench

TWEAK_SCHEDULE_SEQ -- requirements
Module: tweak_schedule_seq

---
 rtl/tweak_schedule_seq.sv | 75 +++++++
 tb/tb_tweak_schedule_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/tweak_schedule_seq.sv
// tweak_schedule_seq: QARMA tweak schedule sequencer; accepts in_tk/in_steps/in_inv on in_valid/in_ready and streams tk_0..tk_N on out_valid/out_ready with out_tk/out_idx/out_last
module tweak_schedule_seq #(
  parameter int CW = 4,
  parameter int MAX_STEPS = 16,
  parameter int SW = $clog2(MAX_STEPS + 1),
  parameter int TW = 16 * CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [TW-1:0] in_tk,
  input  logic [SW-1:0] in_steps,
  input  logic          in_inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] out_tk,
  output logic [SW-1:0] out_idx,
  output logic          out_last
);
  localparam logic [63:0] H = 64'h65EF01237CD489AB;
  localparam logic [63:0] HI = 64'h4567B108CDEF9A23;
  localparam logic [15:0] M = 16'h291B;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [TW-1:0] tk;
  logic [SW-1:0] idx, n;
  logic inv;
  function automatic logic [CW-1:0] om(input logic [CW-1:0] c);
    return {c[0] ^ c[CW == 4 ? 1 : 2], c[CW-1:1]};
  endfunction
  function automatic logic [CW-1:0] om_inv(input logic [CW-1:0] c);
    return {c[CW-2:0], c[CW-1] ^ c[CW == 4 ? 0 : 1]};
  endfunction
  function automatic logic [TW-1:0] upd(input logic [TW-1:0] t, input logic v);
    logic [TW-1:0] u, r;
    u = t;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (v && M[i]) u[TW-1-i*CW -: CW] = om_inv(t[TW-1-i*CW -: CW]);
    for (int i = 0; i < 16; i++)
      r[TW-1-i*CW -: CW] = u[TW-1-int'(v ? HI[63-4*i -: 4] : H[63-4*i -: 4])*CW -: CW];
    for (int i = 0; i < 16; i++)
      if (!v && M[i]) r[TW-1-i*CW -: CW] = om(r[TW-1-i*CW -: CW]);
    return r;
  endfunction
  assign in_ready = state == IDLE;
  assign out_valid = state == RUN;
  assign out_tk = tk;
  assign out_idx = idx;
  assign out_last = state == RUN && idx == n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tk <= '0;
      idx <= '0;
      n <= '0;
      inv <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        state <= RUN;
        tk <= in_tk;
        idx <= '0;
        n <= in_steps > SW'(MAX_STEPS) ? SW'(MAX_STEPS) : in_steps;
        inv <= in_inv;
      end
    end else if (out_ready) begin
      if (idx == n) state <= IDLE;
      else begin
        tk <= upd(tk, inv);
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tweak_schedule_seq.sv
// tb_tweak_schedule_seq: randomized self-checking bench for tweak_schedule_seq against a cell-array reference model
module tb_tweak_schedule_seq;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, in_inv = 0;
  logic out_valid, out_ready = 0, out_last;
  logic [63:0] in_tk = '0, out_tk;
  logic [4:0] in_steps = '0, out_idx;
  int tests = 0, fails = 0;
  int hp[16] = '{6, 5, 14, 15, 0, 1, 2, 3, 7, 12, 13, 4, 8, 9, 10, 11};
  int lf[7] = '{0, 1, 3, 4, 8, 11, 13};
  logic [63:0] beats_q[$], ref_q[$];
  logic [63:0] t, f, f2;
  logic v;
  always #5 clk = ~clk;
  tweak_schedule_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tk(in_tk),
    .in_steps(in_steps), .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready),
    .out_tk(out_tk), .out_idx(out_idx), .out_last(out_last)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int om(input int x);
    return ((x >> 1) | (((x ^ (x >> 1)) & 1) << 3)) & 15;
  endfunction
  function automatic int om_inv(input int y);
    int r;
    r = 0;
    for (int x = 0; x < 16; x++) if (om(x) == y) r = x;
    return r;
  endfunction
  function automatic logic [63:0] mstep(input logic [63:0] tt, input logic iv);
    int c[16], o[16];
    logic [63:0] r;
    for (int i = 0; i < 16; i++) c[i] = int'((tt >> (60 - 4 * i)) & 64'hF);
    if (!iv) begin
      for (int i = 0; i < 16; i++) o[i] = c[hp[i]];
      for (int j = 0; j < 7; j++) o[lf[j]] = om(o[lf[j]]);
    end else begin
      for (int j = 0; j < 7; j++) c[lf[j]] = om_inv(c[lf[j]]);
      for (int i = 0; i < 16; i++) o[hp[i]] = c[i];
    end
    r = '0;
    for (int i = 0; i < 16; i++) r = (r << 4) | 64'(o[i]);
    return r;
  endfunction
  task automatic run(input logic [63:0] tk, input int n, input logic iv, input int stall,
                     input logic hold, input int abort_at, output logic [63:0] fin);
    logic [63:0] exp_tk, sv_tk;
    logic [4:0] sv_idx;
    logic sv_last, stalled, done;
    int k, nn;
    beats_q.delete();
    nn = n > 16 ? 16 : n;
    exp_tk = tk;
    k = 0;
    stalled = 0;
    done = 0;
    fin = '0;
    @(negedge clk);
    check("in_ready idle", 64'(in_ready), 1);
    in_valid = 1;
    in_tk = tk;
    in_steps = 5'(n);
    in_inv = iv;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (hold) begin
        in_tk = {$urandom, $urandom};
        in_steps = 5'($urandom);
        in_inv = ~iv;
      end else in_valid = 0;
      check("out_valid run", 64'(out_valid), 1);
      check("in_ready run", 64'(in_ready), 0);
      if (stalled) begin
        check("stall tk", out_tk, sv_tk);
        check("stall idx", 64'(out_idx), 64'(sv_idx));
        check("stall last", 64'(out_last), 64'(sv_last));
      end
      check("out_idx", 64'(out_idx), 64'(k));
      check("out_tk", out_tk, exp_tk);
      check("out_last", 64'(out_last), 64'(k == nn));
      if (k == abort_at) begin
        rst = 1;
        done = 1;
      end else begin
        out_ready = $urandom_range(99) >= stall;
        stalled = !out_ready;
        sv_tk = out_tk;
        sv_idx = out_idx;
        sv_last = out_last;
        if (out_ready) begin
          beats_q.push_back(out_tk);
          fin = out_tk;
          if (k == nn) begin
            done = 1;
            in_valid = 0;
          end else begin
            exp_tk = mstep(exp_tk, iv);
            k++;
          end
        end
      end
    end
    if (!done) check("timeout", 0, 1);
    @(negedge clk);
    out_ready = 0;
    in_valid = 0;
    if (abort_at < 0) begin
      check("valid after last", 64'(out_valid), 0);
      check("in_ready after last", 64'(in_ready), 1);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst valid", 64'(out_valid), 0);
    check("rst tk", out_tk, 0);
    check("rst idx", 64'(out_idx), 0);
    check("rst last", 64'(out_last), 0);
    rst = 0;
    @(negedge clk);
    check("ready after rst", 64'(in_ready), 1);
    run(64'h0123456789ABCDEF, 1, 0, 0, 0, -1, f);
    check("kat fwd", f, 64'hBAE701233CD28CAB);
    check("kat fwd beats", 64'(beats_q.size()), 2);
    run(64'hBAE701233CD28CAB, 1, 1, 0, 0, -1, f);
    check("kat inv", f, 64'h0123456789ABCDEF);
    t = {$urandom, $urandom};
    run(t, 16, 0, 0, 0, -1, f);
    check("max fwd beats", 64'(beats_q.size()), 17);
    run(f, 16, 1, 0, 0, -1, f2);
    check("max inv beats", 64'(beats_q.size()), 17);
    check("roundtrip", f2, t);
    run({$urandom, $urandom}, 0, 0, 0, 0, -1, f);
    check("n0 beats", 64'(beats_q.size()), 1);
    run({$urandom, $urandom}, 25, 1, 20, 0, -1, f);
    check("clamp beats", 64'(beats_q.size()), 17);
    t = {$urandom, $urandom};
    v = 1'($urandom);
    run(t, 10, v, 0, 0, -1, f);
    ref_q = beats_q;
    run(t, 10, v, 50, 1, -1, f);
    check("bp beats", 64'(beats_q.size()), 64'(ref_q.size()));
    for (int i = 0; i < beats_q.size() && i < ref_q.size(); i++) check("bp seq", beats_q[i], ref_q[i]);
    run({$urandom, $urandom}, 8, 0, 0, 0, 3, f);
    check("abort valid", 64'(out_valid), 0);
    check("abort tk", out_tk, 0);
    check("abort idx", 64'(out_idx), 0);
    check("abort last", 64'(out_last), 0);
    rst = 0;
    run({$urandom, $urandom}, 5, 1, 30, 0, -1, f);
    check("post abort beats", 64'(beats_q.size()), 6);
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(16);
      run({$urandom, $urandom}, n, 1'($urandom), $urandom_range(60), 1'($urandom), -1, f);
      check("rand beats", 64'(beats_q.size()), 64'(n + 1));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
